umi_merger: RTL and testbench
=============================

UMI_MERGER -- requirements
Module: umi_merger

Interface
REQ-001 Parameter AW, default 64: address width of dst_addr/src_addr fields.
REQ-002 Parameter CW, default 32: command width.
REQ-003 Parameter UW, default 256: payload width.
REQ-004 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-005 nreset  input  1  reset, asynchronous, active-low.
REQ-006 umi_resp_in_valid  input  1  response-stream input valid.
REQ-007 umi_resp_in_cmd / _dst_addr / _src_addr / _payload  input  CW / AW / AW / UW  response-stream packet fields.
REQ-008 umi_resp_in_ready  output  1  response-stream input accepted this cycle when high with valid.
REQ-009 umi_req_in_valid  input  1  request-stream input valid.
REQ-010 umi_req_in_cmd / _dst_addr / _src_addr / _payload  input  CW / AW / AW / UW  request-stream packet fields.
REQ-011 umi_req_in_ready  output  1  request-stream input accepted this cycle when high with valid.
REQ-012 umi_out_valid  output  1  merged output valid, registered.
REQ-013 umi_out_cmd / _dst_addr / _src_addr / _payload  output  CW / AW / AW / UW  merged packet fields, registered.
REQ-014 umi_out_ready  input  1  downstream accepts the output packet.

Function
REQ-015 Block SHALL merge two UMI streams into one through a single-entry output register; data path latency is exactly 1 cycle from input handshake to umi_out_valid.
REQ-016 Register can load ("accept") when umi_out_valid==0 or umi_out_ready==1; sustained throughput SHALL be 1 packet/cycle.
REQ-017 Each cycle at most one input SHALL be granted, and only when accept==1; ready for an input = its grant (ready SHALL NOT depend on its own valid beyond arbitration).
REQ-018 Only one input valid: that input is granted when accept==1.
REQ-019 Both valid: winner selected per REQ-030/031; loser's ready SHALL be 0 and its packet remains pending, unchanged.
REQ-020 On a granted handshake, cmd/dst_addr/src_addr/payload of the winner SHALL be captured unmodified and umi_out_valid set to 1 next cycle.
REQ-021 umi_out_valid==1 and umi_out_ready==0: all umi_out_* SHALL hold stable; both input readies SHALL be 0.
REQ-022 umi_out_valid==1, umi_out_ready==1, no input valid: umi_out_valid SHALL clear next cycle.
REQ-023 umi_out_valid==1, umi_out_ready==1, an input valid: new packet SHALL load in same cycle (back-to-back, no bubble).
REQ-024 Neither input valid: no grant, register contents unchanged except per REQ-022.
REQ-025 Inputs are single-beat packets; no lock or multi-cycle grant holding.
REQ-026 No combinational path from umi_out_ready to umi_out_* ; umi_out_ready to input readies is permitted.

Reset
REQ-027 nreset low SHALL asynchronously clear umi_out_valid to 0 and the arbitration pointer (REQ-031) to "request last granted".
REQ-028 umi_out_cmd/dst_addr/src_addr/payload SHALL reset to all-zero.
REQ-029 Input readies SHALL be 0 while nreset is low; first grant possible on the first rising clk edge after nreset deasserts; a packet mid-handshake at reset is dropped.

Configuration
REQ-030 Without UMI_MERGER_RR_EN: fixed priority, response input SHALL always win over request input.
REQ-031 With UMI_MERGER_RR_EN defined: round-robin; one-bit pointer records last granted input, updated only on a completed input handshake; on contention the input not last granted SHALL win; single-requester grants update the pointer too.

Verification
REQ-032 Reset: nreset low mid-traffic -> umi_out_valid=0, outputs 0, both readies 0 immediately, no clk required.
REQ-033 Contention, fixed priority: both valid for 4 cycles, umi_out_ready=1 -> output carries resp cmd 0x01 four times, req ready=0 throughout; with UMI_MERGER_RR_EN -> resp, req, resp, req.
REQ-034 Backpressure: out holds payload 0xA5.., umi_out_ready=0 for 3 cycles -> outputs stable, both readies 0; ready=1 -> next pending packet loads that cycle.
REQ-035 Streaming: req-only valid 8 cycles, cmd incrementing 0x02..0x10 step 2, out_ready=1 -> 8 output packets on consecutive cycles, order preserved, 1-cycle latency.
REQ-036 Drain: one resp packet, then no valids, out_ready=1 -> umi_out_valid high exactly 1 cycle.
REQ-037 Random valid/ready 10k cycles, scoreboard per input -> no loss, duplication, or reordering within a stream.

Source files
------------

// File: rtl/umi_merger.sv
// umi_merger: merges the response and request UMI streams into one registered output; 1-cycle latency, 1 pkt/cycle.
// A held, unaccepted output stalls both inputs. Response-first priority, or round-robin when UMI_MERGER_RR_EN is defined.
module umi_merger #(
  parameter int AW = 64,
  parameter int CW = 32,
  parameter int UW = 256
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          umi_resp_in_valid,
  input  logic [CW-1:0] umi_resp_in_cmd,
  input  logic [AW-1:0] umi_resp_in_dst_addr,
  input  logic [AW-1:0] umi_resp_in_src_addr,
  input  logic [UW-1:0] umi_resp_in_payload,
  output logic          umi_resp_in_ready,
  input  logic          umi_req_in_valid,
  input  logic [CW-1:0] umi_req_in_cmd,
  input  logic [AW-1:0] umi_req_in_dst_addr,
  input  logic [AW-1:0] umi_req_in_src_addr,
  input  logic [UW-1:0] umi_req_in_payload,
  output logic          umi_req_in_ready,
  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dst_addr,
  output logic [AW-1:0] umi_out_src_addr,
  output logic [UW-1:0] umi_out_payload,
  input  logic          umi_out_ready
);

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst_addr;
    logic [AW-1:0] src_addr;
    logic [UW-1:0] payload;
  } pkt_t;

  pkt_t w_resp_pkt;
  pkt_t w_req_pkt;
  pkt_t w_win_pkt;
  pkt_t r_out;
  logic r_out_valid;
  logic w_accept;
  logic w_gnt_resp;
  logic w_gnt_req;

  assign w_resp_pkt = {umi_resp_in_cmd, umi_resp_in_dst_addr, umi_resp_in_src_addr, umi_resp_in_payload};
  assign w_req_pkt  = {umi_req_in_cmd, umi_req_in_dst_addr, umi_req_in_src_addr, umi_req_in_payload};

  // Readies are forced low while reset is asserted, independent of the clock.
  assign w_accept = nreset & (~r_out_valid | umi_out_ready);

`ifdef UMI_MERGER_RR_EN
  logic r_last_req;

  assign w_gnt_resp = w_accept & umi_resp_in_valid & (~umi_req_in_valid | r_last_req);
  assign w_gnt_req  = w_accept & umi_req_in_valid & (~umi_resp_in_valid | ~r_last_req);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_last_req <= 1'b1;
    end else if (w_gnt_resp | w_gnt_req) begin
      r_last_req <= w_gnt_req;
    end
  end
`else
  assign w_gnt_resp = w_accept & umi_resp_in_valid;
  assign w_gnt_req  = w_accept & umi_req_in_valid & ~umi_resp_in_valid;
`endif

  assign w_win_pkt = w_gnt_resp ? w_resp_pkt : w_req_pkt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (w_gnt_resp | w_gnt_req) begin
      r_out_valid <= 1'b1;
      r_out       <= w_win_pkt;
    end else if (umi_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign umi_resp_in_ready = w_gnt_resp;
  assign umi_req_in_ready  = w_gnt_req;
  assign umi_out_valid     = r_out_valid;
  assign umi_out_cmd       = r_out.cmd;
  assign umi_out_dst_addr  = r_out.dst_addr;
  assign umi_out_src_addr  = r_out.src_addr;
  assign umi_out_payload   = r_out.payload;

  a_one_grant: assert property (@(posedge clk) disable iff (!nreset) !(w_gnt_resp && w_gnt_req));
  a_out_hold: assert property (@(posedge clk) disable iff (!nreset)
    (r_out_valid && !umi_out_ready) |=> (r_out_valid && $stable(r_out)));

endmodule

// File: tb/tb_umi_merger.sv
module tb_umi_merger;
  localparam int AW = 64;
  localparam int CW = 32;
  localparam int UW = 256;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [UW-1:0] pl;
  } pkt_t;
  localparam int PW = $bits(pkt_t);

  logic clk = 1'b0;
  logic nreset;
  logic resp_vld_i, req_vld_i, out_rdy;
  pkt_t resp_drv, req_drv;
  logic resp_rdy, req_rdy, out_vld;
  logic [CW-1:0] o_cmd;
  logic [AW-1:0] o_dst, o_src;
  logic [UW-1:0] o_pl;
  pkt_t out_pkt;
  assign out_pkt = {o_cmd, o_dst, o_src, o_pl};

  always #5 clk = ~clk;

  umi_merger #(.AW(AW), .CW(CW), .UW(UW)) dut (
    .clk(clk), .nreset(nreset),
    .umi_resp_in_valid(resp_vld_i), .umi_resp_in_cmd(resp_drv.cmd),
    .umi_resp_in_dst_addr(resp_drv.dst), .umi_resp_in_src_addr(resp_drv.src),
    .umi_resp_in_payload(resp_drv.pl), .umi_resp_in_ready(resp_rdy),
    .umi_req_in_valid(req_vld_i), .umi_req_in_cmd(req_drv.cmd),
    .umi_req_in_dst_addr(req_drv.dst), .umi_req_in_src_addr(req_drv.src),
    .umi_req_in_payload(req_drv.pl), .umi_req_in_ready(req_rdy),
    .umi_out_valid(out_vld), .umi_out_cmd(o_cmd), .umi_out_dst_addr(o_dst),
    .umi_out_src_addr(o_src), .umi_out_payload(o_pl), .umi_out_ready(out_rdy)
  );

  int vecs = 0;
  int errs = 0;
  pkt_t resp_q[$], req_q[$], exp_q[$];
  pkt_t resp_cur, req_cur, last_pkt;
  logic resp_pend = 1'b0, req_pend = 1'b0, last_hs = 1'b0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [31:0] cmd, input logic [31:0] tag);
    pkt_t p;
    p.cmd = cmd;
    p.dst = {tag, 32'hD000_0000};
    p.src = {32'h5000_0000, tag};
    p.pl  = {8{tag ^ cmd}};
    return p;
  endfunction

  function automatic pkt_t rnd();
    pkt_t p;
    p.cmd = $urandom();
    p.dst = {$urandom(), $urandom()};
    p.src = {$urandom(), $urandom()};
    for (int i = 0; i < UW / 32; i++) p.pl[i*32 +: 32] = $urandom();
    return p;
  endfunction

  // One clock of stimulus: drive at negedge, sample handshakes 2ns later.
  task automatic step(input bit r_en, input bit q_en, input bit o_rdy,
                      input bit do_chk, input logic [1:0] exp_rdy);
    @(negedge clk);
    if (last_hs) begin
      chk_i("latency_vld", int'(out_vld), 1);
      chk("latency_pkt", out_pkt, last_pkt);
    end
    last_hs = 1'b0;
    if (!resp_pend && r_en && resp_q.size() > 0) begin
      resp_cur = resp_q.pop_front();
      resp_pend = 1'b1;
    end
    if (!req_pend && q_en && req_q.size() > 0) begin
      req_cur = req_q.pop_front();
      req_pend = 1'b1;
    end
    resp_vld_i = resp_pend;
    resp_drv   = resp_cur;
    req_vld_i  = req_pend;
    req_drv    = req_cur;
    out_rdy    = o_rdy;
    #2;
    chk_i("ready_onehot", int'(resp_rdy & req_rdy), 0);
    if (do_chk) chk_i("ready_pattern", int'({resp_rdy, req_rdy}), int'(exp_rdy));
    if (resp_pend && resp_rdy) begin
      exp_q.push_back(resp_cur);
      last_pkt = resp_cur;
      last_hs = 1'b1;
      resp_pend = 1'b0;
    end
    if (req_pend && req_rdy) begin
      exp_q.push_back(req_cur);
      last_pkt = req_cur;
      last_hs = 1'b1;
      req_pend = 1'b0;
    end
  endtask

  // Output monitor: every output handshake must match the oldest accepted packet.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (nreset && out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL mon_unexpected: got cmd %0h expected no output", o_cmd);
        end else begin
          chk("mon_pkt", out_pkt, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    pkt_t a5;
    logic [1:0] cexp;
    int cnt;
    nreset = 1'b0;
    out_rdy = 1'b1;
    resp_drv = mk(32'h11, 32'h1);
    req_drv = mk(32'h22, 32'h2);
    resp_vld_i = 1'b1;
    req_vld_i = 1'b1;
    #1;
    chk_i("rst_out_vld", int'(out_vld), 0);
    chk("rst_out_pkt", out_pkt, '0);
    chk_i("rst_readies", int'({resp_rdy, req_rdy}), 0);
    @(negedge clk);
    @(negedge clk);
    chk_i("rst_clocked_vld", int'(out_vld), 0);
    chk_i("rst_clocked_rdy", int'({resp_rdy, req_rdy}), 0);
    resp_vld_i = 1'b0;
    req_vld_i = 1'b0;
    nreset = 1'b1;

    // Contention: both inputs loaded with four packets each.
    for (int i = 0; i < 4; i++) begin
      resp_q.push_back(mk(32'h01, 32'h100 + i));
      req_q.push_back(mk(32'h80, 32'h200 + i));
    end
    for (int i = 0; i < 8; i++) begin
`ifdef UMI_MERGER_RR_EN
      cexp = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
      cexp = (i < 4) ? 2'b10 : 2'b01;
`endif
      step(1, 1, 1, 1, cexp);
    end

    // Backpressure: hold 0xA5 packet for three cycles with a request pending.
    a5 = mk(32'hA5, 32'h0);
    a5.pl = {32{8'hA5}};
    resp_q.push_back(a5);
    req_q.push_back(mk(32'h33, 32'h300));
    step(1, 0, 1, 1, 2'b10);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, 2'b00);
      chk_i("bp_vld", int'(out_vld), 1);
      chk("bp_hold", out_pkt, a5);
    end
    step(0, 1, 1, 1, 2'b01);

    // Streaming request-only packets, cmd 0x02..0x10.
    for (int i = 0; i < 8; i++) req_q.push_back(mk(32'(2 * (i + 1)), 32'h400 + i));
    for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 2'b01);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 2'b00);
    chk_i("stream_drained", exp_q.size(), 0);

    // Drain: a single response packet keeps valid high exactly one cycle.
    resp_q.push_back(mk(32'h44, 32'h500));
    step(1, 0, 1, 1, 2'b10);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 2'b00);
      cnt += int'(out_vld);
    end
    chk_i("drain_vld_cycles", cnt, 1);

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) resp_q.push_back(rnd());
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 2'b10);
    resp_vld_i = 1'b1;
    req_vld_i = 1'b1;
    #1;
    nreset = 1'b0;
    #1;
    chk_i("midrst_out_vld", int'(out_vld), 0);
    chk("midrst_out_pkt", out_pkt, '0);
    chk_i("midrst_readies", int'({resp_rdy, req_rdy}), 0);
    resp_q.delete();
    req_q.delete();
    exp_q.delete();
    resp_pend = 1'b0;
    req_pend = 1'b0;
    last_hs = 1'b0;
    @(negedge clk);
    resp_vld_i = 1'b0;
    req_vld_i = 1'b0;
    nreset = 1'b1;
    resp_q.push_back(rnd());
    req_q.push_back(rnd());
    step(1, 1, 1, 1, 2'b10);
    step(0, 1, 1, 1, 2'b01);

    // Random valid/ready traffic.
    for (int c = 0; c < 10000; c++) begin
      if (resp_q.size() < 2) resp_q.push_back(rnd());
      if (req_q.size() < 2) req_q.push_back(rnd());
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0, 0, 2'b00);
    end
    for (int i = 0; i < 100 && (resp_q.size() > 0 || req_q.size() > 0 || resp_pend || req_pend); i++)
      step(1, 1, 1, 0, 2'b00);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(0, 0, 1, 0, 2'b00);
    chk_i("final_pending", int'(resp_pend | req_pend) + resp_q.size() + req_q.size(), 0);
    chk_i("final_exp_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
